// File: rtl/iterative_shift_ctrl.sv
// Multi-cycle RV32I shift unit (SLL/SRL/SRA) that applies a single-bit shift per cycle.
// Optional build macro ITER_SHIFT_FAST4_EN adds a 4-bit step taken while at least 4 shifts remain.
module iterative_shift_ctrl #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic [1:0]         r_state;
    logic [1:0]         r_op;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_result;

    logic               w_step_by4;
    logic [SHAMT_W-1:0] w_cnt_next;
    logic [WIDTH-1:0]   w_work_next;

    always_comb begin
`ifdef ITER_SHIFT_FAST4_EN
        w_step_by4 = (r_cnt >= SHAMT_W'(4));
`else
        w_step_by4 = 1'b0;
`endif
        w_cnt_next  = w_step_by4 ? (r_cnt - SHAMT_W'(4)) : (r_cnt - SHAMT_W'(1));
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_work_next = r_work;
        case (r_op)
            OP_SLL: w_work_next = w_step_by4 ? {r_work[WIDTH-5:0], 4'b0000}
                                             : {r_work[WIDTH-2:0], 1'b0};
            OP_SRL: w_work_next = w_step_by4 ? {4'b0000, r_work[WIDTH-1:4]}
                                             : {1'b0, r_work[WIDTH-1:1]};
            OP_SRA: w_work_next = w_step_by4 ? {{4{r_work[WIDTH-1]}}, r_work[WIDTH-1:4]}
                                             : {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            default: w_work_next = r_work;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= 2'b00;
            r_cnt    <= '0;
            r_work   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_work <= operand;
                        r_op   <= op;
                        r_cnt  <= shamt;
                        if (shamt != '0 && op != OP_RSV) begin
                            r_state <= ST_SHIFT;
                        end else begin
                            r_state  <= ST_DONE;
                            r_result <= operand;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_work_next;
                    r_cnt  <= w_cnt_next;
                    // Last step: the freshly shifted value goes straight into result.
                    if (w_cnt_next == '0) begin
                        r_state  <= ST_DONE;
                        r_result <= w_work_next;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready  = (r_state == ST_IDLE);
    assign busy   = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_iterative_shift_ctrl.sv
// Directed self-checking bench for iterative_shift_ctrl; expected values are hand-computed.
// Define ITER_SHIFT_FAST4_EN for both bench and RTL to check the fast-step latency.
module tb_iterative_shift_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_asserts = 0;
    int n_fail    = 0;

    iterative_shift_ctrl #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .operand (operand),
        .shamt   (shamt),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] o, input int s);
        if (o == 2'b11 || s == 0) return 1;
`ifdef ITER_SHIFT_FAST4_EN
        return s / 4 + s % 4 + 1;
`else
        return s + 1;
`endif
    endfunction

    // Waits for done starting from latency count l0 (edges since and including acceptance).
    task automatic wait_done(input string tag, input int l0, input int lat, input logic [31:0] exp);
        int   l = l0;
        logic busy_ok = 1'b1;
        while (!done && l < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            l++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(l), 32'(lat));
        check({tag, "_result"}, result, exp);
        check({tag, "_busy"}, 32'(busy_ok & busy), 32'd1);
        check({tag, "_ready_low_in_done"}, 32'(ready), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_ready_after"}, 32'(ready), 32'd1);
        check({tag, "_result_held"}, result, exp);
    endtask

    task automatic run_job(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [4:0] s, input logic [31:0] exp);
        op      = o;
        operand = a;
        shamt   = s;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        // Scramble inputs after acceptance; the captured copy must be used.
        operand = ~a;
        shamt   = ~s;
        op      = ~o;
        check({tag, "_accepted"}, 32'(ready), 32'd0);
        wait_done(tag, 1, exp_lat(o, int'(s)), exp);
    endtask

    initial begin
        logic saw_done;
        rst     = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        operand = '0;
        shamt   = '0;
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'h0);
        rst = 1'b0;
        tick();

        run_job("sll5", 2'b00, 32'h0000_0001, 5'd5, 32'h0000_0020);
        run_job("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        run_job("sll31", 2'b00, 32'h0000_0003, 5'd31, 32'h8000_0000);
        run_job("srl4", 2'b01, 32'h8000_00F0, 5'd4, 32'h0800_000F);
        run_job("srl0", 2'b01, 32'h1234_5678, 5'd0, 32'h1234_5678);
        run_job("sra7_pos", 2'b10, 32'h7F00_0000, 5'd7, 32'h00FE_0000);

        // Start pulse while busy must be ignored.
        op = 2'b00; operand = 32'h0000_0001; shamt = 5'd10; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("busy_start_ready", 32'(ready), 32'd0);
        op = 2'b01; operand = 32'hFFFF_FFFF; shamt = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_start", 3, exp_lat(2'b00, 10), 32'h0000_0400);

        // Reset mid-operation aborts without a done pulse.
        op = 2'b00; operand = 32'h0000_0001; shamt = 5'd20; start = 1'b1;
        tick();
        start = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        if (done) saw_done = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_no_done", 32'(saw_done | done), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", result, 32'h0);

        // rst and start together: rst wins.
        rst = 1'b1; start = 1'b1; operand = 32'h0000_00FF; shamt = 5'd3;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_start_ready", 32'(ready), 32'd1);
        check("rst_start_busy", 32'(busy), 32'd0);
        tick();
        check("rst_start_idle", 32'(ready), 32'd1);

        run_job("fresh", 2'b00, 32'h0000_0003, 5'd1, 32'h0000_0006);

        // Reserved op, then a back-to-back start in the cycle after done.
        run_job("rsv", 2'b11, 32'hDEAD_BEEF, 5'd7, 32'hDEAD_BEEF);
        run_job("b2b", 2'b00, 32'h0000_0001, 5'd3, 32'h0000_0008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/iterative_shift_ctrl.md
Name: iterative_shift_ctrl

Overview:
- Multi-cycle shift unit for the RV32I shift instructions SLL/SLLI, SRL/SRLI, SRA/SRAI.
- Its datapath is a single-bit shifter stage, applied once per cycle, which keeps the area small.
- Sits beside the ALU. The core issues a start, stalls on busy, and captures the result on the done pulse.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a shift; sampled only when ready=1.
- op  input  2  00=SLL, 01=SRL, 10=SRA, 11=reserved.
- operand  input  WIDTH  value to shift; captured on accepted start.
- shamt  input  SHAMT_W  shift amount; captured on accepted start.
- ready  output  1  high in IDLE; start is accepted only when high.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  shifted value; held until the next accepted start.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: ready=1, busy=0, done=0, result=0. Internal op_q=0, cnt=0, state=IDLE.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - On start=1, capture operand into the working register, capture op into op_q, load cnt=shamt.
  - Next state is SHIFT if shamt!=0 and op!=11; otherwise DONE.
- SHIFT, each cycle:
  - Working register shifts by one bit; cnt decrements by 1.
  - When cnt reaches 1 (last step), next state is DONE.
- Per-step shift rules:
  - SLL: {w[WIDTH-2:0],1'b0}.
  - SRL: {1'b0,w[WIDTH-1:1]}.
  - SRA: {w[WIDTH-1],w[WIDTH-1:1]}.
- DONE:
  - done=1 for exactly one cycle; result is driven from the working register.
  - Next state is IDLE. ready is low in this cycle.
- Latency: start accepted at edge T, done high in cycle T+shamt+1.
  - shamt=0 gives done at T+1 with result=operand.
  - shamt=31 gives done at T+32.
- Reserved op=11: no shift; done at T+1 with result=operand.
- start while ready=0 is ignored; no queuing.
- operand, shamt and op may change after acceptance without effect.
- result keeps its last value in IDLE. It updates only from the working register on entering DONE.
- rst asserted mid-operation: next edge forces IDLE and the reset values. No done pulse is emitted for the aborted operation.
- rst and start asserted together: rst wins and start is dropped.

Optional Feature:
- Macro: ITER_SHIFT_FAST4_EN.
- When defined:
  - In SHIFT, if cnt>=4, the working register shifts by 4 in one step and cnt decrements by 4. Otherwise it shifts by 1.
  - Latency becomes T + floor(shamt/4) + (shamt mod 4) + 1. Example: shamt=31 gives done at T+11.
  - Shift fill rules per op are unchanged (zero fill, or sign replication for SRA).
- When undefined: only the 1-bit step exists; latency is as stated above.

Test Plan:
1. SLL: reset, then start with op=00, operand=32'h0000_0001, shamt=5 → done at T+6, result=32'h0000_0020, busy high during T+1..T+6.
2. SRA: op=10, operand=32'h8000_0000, shamt=31 → result=32'hFFFF_FFFF, done at T+32 (T+11 with ITER_SHIFT_FAST4_EN).
3. SRL and zero shift:
   - op=01, operand=32'h8000_00F0, shamt=4 → result=32'h0800_000F.
   - Then op=01, shamt=0, operand=32'h1234_5678 → done at T+1, result=32'h1234_5678.
4. Busy-window start: mid-SHIFT of an op=00, operand=32'h1, shamt=10 job, pulse start with operand=32'hFFFF_FFFF → ignored; result=32'h0000_0400 at T+11.
5. Reset mid-operation: start shamt=20, assert rst at T+5 for one cycle → ready=1, busy=0, result=0 next cycle; no done pulse. A fresh op=00, operand=32'h3, shamt=1 → result=32'h6.
6. Reserved op=11, operand=32'hDEAD_BEEF, shamt=7 → done at T+1, result=32'hDEAD_BEEF. A back-to-back start issued in the cycle after done is accepted.
